// File: rtl/serial_readout_pkg.sv
// serial_readout_pkg: shared defaults, sclk edge encoding and FSM state type
package serial_readout_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DEPTH     = 65536;
    localparam int DEF_MSB_FIRST = 1;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;

    // LOAD waits for word 0, PREF/CAPT capture the prefetched next word, RUN streams
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PREF,
        S_RUN,
        S_CAPT
    } state_t;

endpackage

// File: rtl/serial_readout_if.sv
// serial_readout_if: host serial pins plus word-memory read port
interface serial_readout_if
    import serial_readout_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              sclk;
    logic              cs_n;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              miso;
    logic              busy;
    logic              frame_done;

    modport master (
        output sclk, cs_n, data,
        input  addr, rd_en, miso, busy, frame_done
    );

    modport slave (
        input  sclk, cs_n, data,
        output addr, rd_en, miso, busy, frame_done
    );

endinterface

// File: rtl/serial_readout_sync_edge.sv
// sync_edge: two-flop synchroniser with a history flop giving level, rise and fall
module sync_edge #(
    parameter logic HIST_RST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // metastability stages followed by the history stage used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= HIST_RST;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/serial_readout.sv
// serial_readout: streams memory words out on miso, one bit per active host sclk edge
module serial_readout
    import serial_readout_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int EDGE      = EDGE_RISE,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input logic        clk,
    input logic        rst,
    serial_readout_if.slave bus
);

    localparam int                CNT_W     = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall, w_sclk_act;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx, w_addr_inc;
    logic              r_rd_en, w_rd_en_nx;
    logic              r_miso, w_miso_nx;
    logic              r_busy, w_busy_nx;
    logic              r_done, w_done_nx;
    logic              r_armed, w_armed_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [DATA_W-1:0] r_shift, w_shift_nx, w_adv;
    logic [DATA_W-1:0] r_next, w_next_nx;
    logic              w_shifting;

    sync_edge #(.HIST_RST(1'b0)) u_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_d     (bus.sclk),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // cs_n history resets high so a low cs_n after reset reads as a fall that arming ignores
    sync_edge #(.HIST_RST(1'b1)) u_cs (
        .clk     (clk),
        .rst     (rst),
        .i_d     (bus.cs_n),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    assign w_sclk_act = (w_sclk_rise | w_sclk_fall) & (w_sclk_lvl == (EDGE == EDGE_RISE));
    assign w_addr_inc = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_adv      = advance(r_shift);
    assign w_shifting = w_sclk_act && r_busy && (r_state != S_LOAD);

    // next-state and datapath: cs_n rise aborts first, then cs_n fall restarts, then shifting
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_rd_en_nx = 1'b0;
        w_miso_nx  = r_miso;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_armed_nx = r_armed | w_cs_lvl;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_next_nx  = r_next;
        if (w_cs_rise) begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
            w_miso_nx  = 1'b0;
            w_cnt_nx   = '0;
        end else if (w_cs_fall && r_armed) begin
            w_state_nx = S_LOAD;
            w_busy_nx  = 1'b1;
            w_addr_nx  = '0;
            w_rd_en_nx = 1'b1;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    w_shift_nx = bus.data;
                    w_miso_nx  = first_bit(bus.data);
                    w_addr_nx  = w_addr_inc;
                    w_rd_en_nx = 1'b1;
                    w_state_nx = S_PREF;
                end
                S_PREF, S_CAPT: begin
                    w_next_nx  = bus.data;
                    w_state_nx = S_RUN;
                end
                default: ;
            endcase
            if (w_shifting) begin
                if (r_cnt == LAST_BIT) begin
                    w_shift_nx = r_next;
                    w_miso_nx  = first_bit(r_next);
                    w_cnt_nx   = '0;
                    w_addr_nx  = w_addr_inc;
                    w_rd_en_nx = 1'b1;
                    w_done_nx  = (r_addr == '0);
                    w_state_nx = S_CAPT;
                end else begin
                    w_shift_nx = w_adv;
                    w_miso_nx  = first_bit(w_adv);
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_next  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_rd_en <= w_rd_en_nx;
            r_miso  <= w_miso_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_armed <= w_armed_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_next  <= w_next_nx;
        end
    end

    assign bus.addr       = r_addr;
    assign bus.rd_en      = r_rd_en;
    assign bus.miso       = r_miso;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule

// File: tb/tb_serial_readout.sv
// tb_serial_readout: two configurations driven by one host, checked against a bit-stream model
module tb_serial_readout;
    import serial_readout_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;

    always #5 clk = ~clk;

    serial_readout_if #(.DATA_W(16), .ADDR_W(16)) ifa ();
    serial_readout_if #(.DATA_W(16), .ADDR_W(16)) ifb ();

    assign ifa.sclk = sclk;
    assign ifa.cs_n = cs_n;
    assign ifb.sclk = sclk;
    assign ifb.cs_n = cs_n;

    serial_readout #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .EDGE(EDGE_RISE), .MSB_FIRST(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    serial_readout #(.DATA_W(16), .ADDR_W(16), .DEPTH(3), .EDGE(EDGE_FALL), .MSB_FIRST(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    logic [15:0] mem [2][4];
    int          depth    [2] = '{4, 3};
    bit          fall_act [2] = '{1'b0, 1'b1};
    bit          msb      [2] = '{1'b1, 1'b0};

    int          n_act    [2] = '{0, 0};
    int          done_act [2] = '{0, 0};
    logic [15:0] act_rd   [2][256];

    int          n_exp    [2] = '{0, 0};
    int          n_chk    [2] = '{0, 0};
    int          done_exp [2] = '{0, 0};
    logic [15:0] exp_rd   [2][256];
    logic [15:0] eaddr    [2] = '{16'd0, 16'd0};
    int          k        [2] = '{0, 0};
    bit          act      [2] = '{1'b0, 1'b0};
    bit          armed = 1'b0;

    int total = 0;
    int bad   = 0;

    // word memories: data appears one clk after the read strobe
    always @(negedge clk) begin
        if (ifa.rd_en === 1'b1) ifa.data <= mem[0][ifa.addr[1:0]];
        if (ifb.rd_en === 1'b1) ifb.data <= mem[1][ifb.addr[1:0]];
    end

    // record every read address and frame_done pulse
    always @(posedge clk) begin
        if (ifa.rd_en === 1'b1 && n_act[0] < 256) begin
            act_rd[0][n_act[0]] <= ifa.addr;
            n_act[0] <= n_act[0] + 1;
        end
        if (ifb.rd_en === 1'b1 && n_act[1] < 256) begin
            act_rd[1][n_act[1]] <= ifb.addr;
            n_act[1] <= n_act[1] + 1;
        end
        if (ifa.frame_done === 1'b1) done_act[0] <= done_act[0] + 1;
        if (ifb.frame_done === 1'b1) done_act[1] <= done_act[1] + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // expected miso: bit k of the concatenated word stream, 0 outside a frame
    function automatic logic exp_miso(input int d);
        logic [15:0] w;
        int          p;
        if (!act[d]) return 1'b0;
        w = mem[d][(k[d] / 16) % depth[d]];
        p = msb[d] ? 15 - (k[d] % 16) : k[d] % 16;
        return w[p];
    endfunction

    task automatic push_rd(input int d, input int a);
        exp_rd[d][n_exp[d]] = 16'(a);
        n_exp[d]++;
        eaddr[d] = 16'(a);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".miso"},  d, (d == 0) ? ifa.miso : ifb.miso, exp_miso(d));
            chk({tag, ".busy"},  d, (d == 0) ? ifa.busy : ifb.busy, act[d]);
            chk({tag, ".addr"},  d, (d == 0) ? ifa.addr : ifb.addr, eaddr[d]);
            chk({tag, ".rd_en"}, d, (d == 0) ? ifa.rd_en : ifb.rd_en, 0);
            chk({tag, ".done"},  d, (d == 0) ? ifa.frame_done : ifb.frame_done, 0);
            chk({tag, ".rd_cnt"},   d, n_act[d], n_exp[d]);
            chk({tag, ".done_cnt"}, d, done_act[d], done_exp[d]);
            for (int i = n_chk[d]; i < n_exp[d] && i < n_act[d]; i++)
                chk({tag, ".rd_addr"}, d, act_rd[d][i], exp_rd[d][i]);
            n_chk[d] = n_exp[d];
        end
    endtask

    task automatic sclk_half(input logic lvl);
        sclk = lvl;
        wait_clks($urandom_range(5, 8));
        for (int d = 0; d < 2; d++) begin
            if (act[d] && (lvl == !fall_act[d])) begin
                k[d]++;
                if (k[d] % 16 == 0) begin
                    push_rd(d, (k[d] / 16 + 1) % depth[d]);
                    if (k[d] % (16 * depth[d]) == 0) done_exp[d]++;
                end
            end
        end
        check_all(lvl ? "rise" : "fall");
    endtask

    task automatic periods(input int n);
        repeat (n) begin
            sclk_half(1'b1);
            sclk_half(1'b0);
        end
    endtask

    task automatic cs_set(input logic lvl);
        cs_n = lvl;
        wait_clks(7);
        for (int d = 0; d < 2; d++) begin
            if (lvl) act[d] = 1'b0;
            else if (armed) begin
                act[d] = 1'b1;
                k[d] = 0;
                push_rd(d, 0);
                push_rd(d, 1);
            end
        end
        if (lvl) armed = 1'b1;
        check_all(lvl ? "cs_hi" : "cs_lo");
    endtask

    initial begin
        mem[0] = '{16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF};
        mem[1] = '{16'h0003, 16'($urandom), 16'($urandom), 16'($urandom)};

        wait_clks(3);
        check_all("reset");
        rst = 1'b0;
        wait_clks(4);
        armed = 1'b1;
        check_all("idle");

        // 1.5 frames for the 4-word rising-edge unit, 2 frames for the 3-word falling-edge unit
        cs_set(1'b0);
        periods(96);

        // abort mid-word, sclk ignored while deselected, restart at word 0
        periods(7);
        cs_set(1'b1);
        periods(3);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) mem[d][i] = 16'($urandom);
        cs_set(1'b0);

        // cs_n rise coinciding with the rising edge that would complete word 1
        periods(31);
        sclk = 1'b1;
        cs_n = 1'b1;
        wait_clks(7);
        act[0] = 1'b0;
        act[1] = 1'b0;
        check_all("cs_sclk");
        sclk_half(1'b0);

        // reset mid-frame with cs_n held low: no resumption until cs_n toggles
        cs_set(1'b0);
        periods(10);
        rst = 1'b1;
        wait_clks(1);
        act[0] = 1'b0;
        act[1] = 1'b0;
        eaddr[0] = 16'd0;
        eaddr[1] = 16'd0;
        armed = 1'b0;
        check_all("rst_mid");
        rst = 1'b0;
        wait_clks(4);
        periods(5);
        cs_set(1'b1);
        cs_set(1'b0);
        periods(20);
        cs_set(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
